// File: rtl/de0qsys_led_blink_pio_if.sv
// de0qsys_led_blink_pio_if: Avalon-MM slave bus bundle for the LED blink PIO
`timescale 1ns/1ps
interface de0qsys_led_blink_pio_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  modport master(output address, chipselect, write_n, writedata, input readdata);
  modport slave(input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/de0qsys_led_blink_pio.sv
// de0qsys_led_blink_pio: LED PIO with atomic set/clear/toggle and per-bit blink from a prescaled timer
`timescale 1ns/1ps
module de0qsys_led_blink_pio #(
  parameter int               WIDTH       = 10,
  parameter int               CLK_DIV     = 50000,
  parameter int               PERIOD_W    = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  de0qsys_led_blink_pio_if.slave  bus,
  output logic [WIDTH-1:0]        out_port
);
  localparam int PW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [WIDTH-1:0]    r_data, r_blink_en, w_data_nxt, w_wd;
  logic [PERIOD_W-1:0] r_period, r_tick_cnt;
  logic [PW-1:0]       r_presc;
  logic                r_phase, w_wr, w_tick, w_restart, w_wd_unused;
  assign w_wr        = bus.chipselect & ~bus.write_n;
  assign w_wd        = bus.writedata[WIDTH-1:0];
  assign w_wd_unused = ^bus.writedata;
  assign w_restart   = w_wr && bus.address == 3'd5;
  assign w_tick      = r_presc == PW'(CLK_DIV - 1);
  assign w_data_nxt  = !w_wr                ? r_data :
                       bus.address == 3'd0  ? w_wd :
                       bus.address == 3'd1  ? r_data | w_wd :
                       bus.address == 3'd2  ? r_data & ~w_wd :
                       bus.address == 3'd3  ? r_data ^ w_wd : r_data;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data     <= RESET_VALUE;
      r_blink_en <= '0;
      r_period   <= '0;
    end else begin
      r_data <= w_data_nxt;
      if (w_wr && bus.address == 3'd4) r_blink_en <= w_wd;
      if (w_restart) r_period <= bus.writedata[PERIOD_W-1:0];
    end
  end
  // A PERIOD write restarts the whole timer so the new half-period starts cleanly at phase 1
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc    <= '0;
      r_tick_cnt <= '0;
      r_phase    <= 1'b1;
    end else if (w_restart) begin
      r_presc    <= '0;
      r_tick_cnt <= '0;
      r_phase    <= 1'b1;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
      if (r_period == '0) begin
        r_tick_cnt <= '0;
        r_phase    <= 1'b1;
      end else if (w_tick) begin
        r_tick_cnt <= r_tick_cnt == r_period - PERIOD_W'(1) ? '0 : r_tick_cnt + PERIOD_W'(1);
        if (r_tick_cnt == r_period - PERIOD_W'(1)) r_phase <= ~r_phase;
      end
    end
  end
  assign out_port     = r_data & ~(r_blink_en & {WIDTH{~r_phase}});
  assign bus.readdata = bus.address <= 3'd3 ? 32'(r_data) :
                        bus.address == 3'd4 ? 32'(r_blink_en) :
                        bus.address == 3'd5 ? 32'(r_period) :
                        bus.address == 3'd6 ? {16'(r_tick_cnt), 15'd0, r_phase} : 32'd0;
endmodule

// File: tb/tb_de0qsys_led_blink_pio.sv
// tb_de0qsys_led_blink_pio: scoreboard bench against an elapsed-time model of the LED blink PIO
`timescale 1ns/1ps
module tb_de0qsys_led_blink_pio;
  localparam int CLK_DIV = 4;
  logic clk, reset_n;
  logic [9:0] out_port;
  de0qsys_led_blink_pio_if bus();
  de0qsys_led_blink_pio #(.WIDTH(10), .CLK_DIV(CLK_DIV), .PERIOD_W(16), .RESET_VALUE('0)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .out_port(out_port));
  typedef struct packed {
    int          due;
    logic        is_rd;
    logic [2:0]  a;
    logic [31:0] exp;
  } item_t;
  item_t q[$];
  int cyc = 0, n_pass = 0, n_total = 0;
  logic [9:0] m_data, m_ben;
  int m_per, m_e;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
  endtask
  // Phase is derived from elapsed time since the last timer restart
  function automatic logic ph(int m);
    int t;
    if (m_per == 0) return 1'b1;
    t = (m - m_e) / CLK_DIV;
    return ((t / m_per) % 2) == 0;
  endfunction
  function automatic logic [31:0] rd_exp(logic [2:0] a, int m);
    logic [31:0] tc;
    tc = m_per == 0 ? 0 : ((m - m_e) / CLK_DIV) % m_per;
    if (a <= 3) return {22'd0, m_data};
    if (a == 4) return {22'd0, m_ben};
    if (a == 5) return m_per;
    if (a == 6) return {tc[15:0], 15'd0, ph(m)};
    return 32'd0;
  endfunction
  function automatic logic [31:0] out_exp(int m);
    return {22'd0, m_data & ~(m_ben & {10{~ph(m)}})};
  endfunction
  always @(negedge clk)
    while (q.size() > 0 && q[0].due <= cyc) begin
      item_t it;
      it = q.pop_front();
      if (it.due < cyc) chk("stale_item", 32'(it.due), 32'(cyc));
      else if (it.is_rd) chk($sformatf("readdata[a=%0d]", it.a), bus.readdata, it.exp);
      else chk("out_port", {22'd0, out_port}, it.exp);
    end
  task automatic drive(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] wd);
    int n;
    @(posedge clk);
    #1;
    bus.chipselect = cs;
    bus.write_n    = wn;
    bus.address    = a;
    bus.writedata  = wd;
    n = cyc;
    q.push_back('{n, 1'b1, a, rd_exp(a, n)});
    if (cs && !wn)
      case (a)
        3'd0: m_data = wd[9:0];
        3'd1: m_data = m_data | wd[9:0];
        3'd2: m_data = m_data & ~wd[9:0];
        3'd3: m_data = m_data ^ wd[9:0];
        3'd4: m_ben  = wd[9:0];
        3'd5: begin m_per = int'(wd[15:0]); m_e = n + 1; end
        default: ;
      endcase
    q.push_back('{n + 1, 1'b0, 3'd0, out_exp(n + 1)});
  endtask
  task automatic wr(input logic [2:0] a, input logic [31:0] wd);
    drive(1'b1, 1'b0, a, wd);
  endtask
  task automatic idle(input int k, input logic [2:0] a);
    for (int i = 0; i < k; i++) drive(1'b0, 1'b1, a, 32'hFFFF_FFFF);
  endtask
  task automatic model_reset();
    m_data = '0;
    m_ben  = '0;
    m_per  = 0;
    m_e    = cyc;
  endtask
  task automatic rand_ops(input int k);
    for (int i = 0; i < k; i++) begin
      logic [2:0] a;
      logic [31:0] wd;
      a  = 3'($urandom_range(0, 7));
      wd = a == 3'd5 ? (($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 4))) : $urandom;
      drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), a, wd);
    end
  endtask
  initial begin
    reset_n = 1'b0;
    bus.chipselect = 1'b0;
    bus.write_n = 1'b1;
    bus.address = 3'd0;
    bus.writedata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    model_reset();
    idle(1, 3'd0);
    idle(1, 3'd5);
    idle(1, 3'd6);
    idle(1, 3'd7);
    wr(3'd0, 32'h0F0);
    wr(3'd1, 32'h003);
    wr(3'd2, 32'h010);
    wr(3'd3, 32'h201);
    idle(1, 3'd1);
    idle(1, 3'd2);
    idle(1, 3'd3);
    wr(3'd0, 32'h3FF);
    wr(3'd4, 32'h005);
    wr(3'd5, 32'h0003);
    idle(40, 3'd6);
    for (int i = 0; i < 50 && ph(cyc); i++) idle(1, 3'd6);
    wr(3'd5, 32'h0002);
    idle(20, 3'd6);
    wr(3'd5, 32'h0000);
    wr(3'd4, 32'h3FF);
    wr(3'd0, 32'h155);
    idle(1000, 3'd6);
    rand_ops(600);
    wr(3'd0, 32'h3FF);
    wr(3'd4, 32'h3FF);
    wr(3'd5, 32'h0001);
    idle(7, 3'd6);
    repeat (2) @(posedge clk);
    #2;
    q.delete();
    bus.address = 3'd6;
    reset_n = 1'b0;
    #1 chk("rst_out_port", {22'd0, out_port}, 32'd0);
    chk("rst_status", bus.readdata, 32'h1);
    bus.address = 3'd0;
    #1 chk("rst_data", bus.readdata, 32'd0);
    bus.address = 3'd4;
    #1 chk("rst_blink_en", bus.readdata, 32'd0);
    bus.address = 3'd5;
    #1 chk("rst_period", bus.readdata, 32'd0);
    repeat (2) @(posedge clk);
    #1 chk("rst_hold_out_port", {22'd0, out_port}, 32'd0);
    reset_n = 1'b1;
    model_reset();
    rand_ops(300);
    repeat (3) @(posedge clk);
    if (q.size() != 0) chk("queue_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
